// File: rtl/apple_placer.sv
// apple_placer
//   Places the apple on a grid cell that is clear of the snake body. It detects
//   the head eating the apple, pulses eaten and bumps the saturating score, and
//   requests a fresh candidate from random_position. Each candidate is checked
//   against every body segment through a segment read port with 1-cycle latency.
//
// Ports
//   clk, reset             clock; synchronous active-high reset
//   move_tick              1-cycle pulse, snake head just advanced
//   head_x, head_y         head position (grid aligned)
//   snake_len              body segments including head (>=1)
//   seg_addr               body segment read address
//   seg_x, seg_y           segment coordinates, valid 1 cycle after seg_addr
//   new_number_trigger     rising edge makes random_position sample new coords
//   rand_x, rand_y         random_position outputs
//   apple_x, apple_y       current apple position (grid aligned)
//   apple_valid            apple placed and drawable
//   eaten                  1-cycle pulse, snake must grow
//   score                  apples eaten, saturating
module apple_placer #(
  parameter int BIT       = 10,
  parameter int GRID_LOG2 = 4,
  parameter int LEN_W     = 6,
  parameter int MAX_RETRY = 8,
  parameter int SCORE_W   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               move_tick,
  input  logic [BIT-1:0]     head_x,
  input  logic [BIT-1:0]     head_y,
  input  logic [LEN_W-1:0]   snake_len,
  output logic [LEN_W-1:0]   seg_addr,
  input  logic [BIT-1:0]     seg_x,
  input  logic [BIT-1:0]     seg_y,
  output logic               new_number_trigger,
  input  logic [BIT-1:0]     rand_x,
  input  logic [BIT-1:0]     rand_y,
  output logic [BIT-1:0]     apple_x,
  output logic [BIT-1:0]     apple_y,
  output logic               apple_valid,
  output logic               eaten,
  output logic [SCORE_W-1:0] score
);

  localparam int RETRY_W = $clog2(MAX_RETRY + 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);
  // Clears the sub-cell bits so a candidate lands on a grid cell.
  localparam logic [BIT-1:0] GRID_MASK = ~((BIT'(1) << GRID_LOG2) - BIT'(1));

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRIGGER,
    S_WAIT,
    S_CAPTURE,
    S_CHECK,
    S_PLACE
  } state_t;

  state_t             state_q;
  logic [BIT-1:0]     apple_x_q, apple_y_q;
  logic [BIT-1:0]     cand_x_q, cand_y_q;
  logic               apple_valid_q;
  logic               eaten_q;
  logic               trig_q;
  logic [SCORE_W-1:0] score_q;
  logic [LEN_W-1:0]   seg_addr_q;
  logic [LEN_W-1:0]   len_q;
  logic [RETRY_W-1:0] retry_q;
  logic               pend_q;  // seg_x/seg_y hold data for the previously issued address
  logic               last_q;  // that previously issued address was the final segment

  logic hit;
  logic head_on_apple;
  logic addr_is_last;

  assign hit           = (seg_x == cand_x_q) && (seg_y == cand_y_q);
  assign head_on_apple = (head_x == apple_x_q) && (head_y == apple_y_q);
  assign addr_is_last  = (seg_addr_q == len_q - LEN_W'(1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_WAIT;
      apple_x_q     <= '0;
      apple_y_q     <= '0;
      cand_x_q      <= '0;
      cand_y_q      <= '0;
      apple_valid_q <= 1'b0;
      eaten_q       <= 1'b0;
      trig_q        <= 1'b0;
      score_q       <= '0;
      seg_addr_q    <= '0;
      len_q         <= LEN_W'(1);
      retry_q       <= '0;
      pend_q        <= 1'b0;
      last_q        <= 1'b0;
    end else begin
      eaten_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (move_tick && head_on_apple) begin
            eaten_q       <= 1'b1;
            if (score_q != '1) score_q <= score_q + SCORE_W'(1);
            apple_valid_q <= 1'b0;
            trig_q        <= 1'b1;
            state_q       <= S_TRIGGER;
          end
        end
        S_TRIGGER: begin
          trig_q  <= 1'b0;
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          cand_x_q   <= rand_x & GRID_MASK;
          cand_y_q   <= rand_y & GRID_MASK;
          seg_addr_q <= '0;
          // A zero length would make the last-address compare wrap; treat it as 1.
          len_q      <= (snake_len == '0) ? LEN_W'(1) : snake_len;
          pend_q     <= 1'b0;
          last_q     <= 1'b0;
          state_q    <= S_CHECK;
        end
        S_CHECK: begin
          // Address issue runs one cycle ahead of the compare; the address
          // parks on the last segment while its data is still in flight.
          if (pend_q && hit) begin
            pend_q <= 1'b0;
            if (retry_q < RETRY_MAX) begin
              retry_q <= retry_q + RETRY_W'(1);
              trig_q  <= 1'b1;
              state_q <= S_TRIGGER;
            end else begin
              state_q <= S_PLACE;
            end
          end else if (pend_q && last_q) begin
            pend_q  <= 1'b0;
            state_q <= S_PLACE;
          end else begin
            pend_q <= 1'b1;
            last_q <= addr_is_last;
            if (!addr_is_last) seg_addr_q <= seg_addr_q + LEN_W'(1);
          end
        end
        S_PLACE: begin
          apple_x_q     <= cand_x_q;
          apple_y_q     <= cand_y_q;
          apple_valid_q <= 1'b1;
          retry_q       <= '0;
          seg_addr_q    <= '0;
          state_q       <= S_IDLE;
        end
        default: begin
          state_q <= S_WAIT;
        end
      endcase
    end
  end

  assign seg_addr           = seg_addr_q;
  assign new_number_trigger = trig_q;
  assign apple_x            = apple_x_q;
  assign apple_y            = apple_y_q;
  assign apple_valid        = apple_valid_q;
  assign eaten              = eaten_q;
  assign score              = score_q;

endmodule

// File: tb/tb_apple_placer.sv
module tb_apple_placer;

  localparam int BIT       = 10;
  localparam int GRID      = 16;
  localparam int LEN_W     = 6;
  localparam int MAX_RETRY = 8;
  localparam int SCORE_W   = 8;
  localparam int SCORE_MAX = 255;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               move_tick = 1'b0;
  logic [BIT-1:0]     head_x = '0, head_y = '0;
  logic [LEN_W-1:0]   snake_len = LEN_W'(1);
  logic [LEN_W-1:0]   seg_addr;
  logic [BIT-1:0]     seg_x, seg_y;
  logic               new_number_trigger;
  logic [BIT-1:0]     rand_x, rand_y;
  logic [BIT-1:0]     apple_x, apple_y;
  logic               apple_valid;
  logic               eaten;
  logic [SCORE_W-1:0] score;

  apple_placer #(
    .BIT(BIT), .GRID_LOG2(4), .LEN_W(LEN_W), .MAX_RETRY(MAX_RETRY), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .reset(reset), .move_tick(move_tick),
    .head_x(head_x), .head_y(head_y), .snake_len(snake_len),
    .seg_addr(seg_addr), .seg_x(seg_x), .seg_y(seg_y),
    .new_number_trigger(new_number_trigger), .rand_x(rand_x), .rand_y(rand_y),
    .apple_x(apple_x), .apple_y(apple_y), .apple_valid(apple_valid),
    .eaten(eaten), .score(score)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Snake body memory with a 1-cycle read latency.
  logic [BIT-1:0] body_x [64];
  logic [BIT-1:0] body_y [64];
  always @(posedge clk) begin
    seg_x <= body_x[seg_addr];
    seg_y <= body_y[seg_addr];
  end

  // random_position stand-in: resets to (200,240), loads the next queued
  // coordinate pair on each trigger rising edge.
  int feed_x[$], feed_y[$];
  logic trig_prev;
  int tx, ty;
  always @(posedge clk) begin
    if (reset) begin
      rand_x    <= BIT'(200);
      rand_y    <= BIT'(240);
      trig_prev <= 1'b0;
    end else begin
      trig_prev <= new_number_trigger;
      if (new_number_trigger && !trig_prev) begin
        if (feed_x.size() > 0) begin
          tx = feed_x.pop_front();
          ty = feed_y.pop_front();
        end else begin
          tx = int'($urandom_range(1023));
          ty = int'($urandom_range(1023));
        end
        rand_x <= BIT'(tx);
        rand_y <= BIT'(ty);
      end
    end
  end

  // Scoreboard expectations.
  int exp_ax[$], exp_ay[$], exp_trig[$], exp_score[$];

  // Monitor: compares whenever the DUT presents eaten or a new placement.
  int   trig_cnt = 0;
  logic valid_prev = 1'b0;
  int   e;
  always @(negedge clk) begin
    if (reset) begin
      trig_cnt   = 0;
      valid_prev = 1'b0;
    end else begin
      if (new_number_trigger) trig_cnt++;
      if (eaten) begin
        if (exp_score.size() == 0) begin
          chk("eaten_unexpected", 1, 0);
        end else begin
          e = exp_score.pop_front();
          chk("score_on_eat", int'(score), e);
          chk("valid_low_on_eat", int'(apple_valid), 0);
        end
      end
      if (apple_valid && !valid_prev) begin
        if (exp_ax.size() == 0) begin
          chk("place_unexpected", 1, 0);
        end else begin
          chk("apple_x", int'(apple_x), exp_ax.pop_front());
          chk("apple_y", int'(apple_y), exp_ay.pop_front());
          chk("trigger_count", trig_cnt, exp_trig.pop_front());
        end
        trig_cnt = 0;
      end
      valid_prev = apple_valid;
    end
  end

  // Reference model state.
  int cand_x[$], cand_y[$];
  int score_m = 0;
  int cur_ax = 0, cur_ay = 0;

  // Walk candidates in order: snap to the grid, accept the first one that
  // misses every body segment, or the one after MAX_RETRY rejections.
  function automatic int place_model(input int len, output int ax, output int ay);
    int rejects = 0;
    ax = 0; ay = 0;
    for (int i = 0; i < cand_x.size(); i++) begin
      int sx = (cand_x[i] / GRID) * GRID;
      int sy = (cand_y[i] / GRID) * GRID;
      bit on_body = 0;
      for (int j = 0; j < len; j++)
        if (int'(body_x[j]) == sx && int'(body_y[j]) == sy) on_body = 1;
      if (!on_body || rejects == MAX_RETRY) begin
        ax = sx; ay = sy;
        return i + 1;
      end
      rejects++;
    end
    return cand_x.size();
  endfunction

  task automatic set_body(input int len);
    for (int j = 0; j < 64; j++) begin
      body_x[j] = BIT'($urandom_range(63) * GRID);
      body_y[j] = BIT'($urandom_range(63) * GRID);
    end
    snake_len = LEN_W'(len);
  endtask

  task automatic fill_random(input int pct, input bit from_reset);
    cand_x.delete(); cand_y.delete();
    if (from_reset) begin cand_x.push_back(200); cand_y.push_back(240); end
    while (cand_x.size() < MAX_RETRY + 1) begin
      if (int'($urandom_range(99)) < pct) begin
        int j = int'($urandom_range(int'(snake_len) - 1));
        cand_x.push_back(int'(body_x[j]) + int'($urandom_range(GRID - 1)));
        cand_y.push_back(int'(body_y[j]) + int'($urandom_range(GRID - 1)));
      end else begin
        cand_x.push_back(int'($urandom_range(1023)));
        cand_y.push_back(int'($urandom_range(1023)));
      end
    end
  endtask

  // Queue the consumed candidates to the random source and the expected result.
  task automatic expect_place(input bit from_reset, output int consumed);
    int ax, ay;
    consumed = place_model(int'(snake_len), ax, ay);
    for (int i = (from_reset ? 1 : 0); i < consumed; i++) begin
      feed_x.push_back(cand_x[i]);
      feed_y.push_back(cand_y[i]);
    end
    exp_ax.push_back(ax);
    exp_ay.push_back(ay);
    exp_trig.push_back(from_reset ? consumed - 1 : consumed);
    cur_ax = ax;
    cur_ay = ay;
  endtask

  task automatic wait_placed(input int max_cyc, output int n);
    n = 0;
    while (!apple_valid && n < max_cyc) begin
      @(negedge clk);
      n++;
    end
    if (!apple_valid) chk("place_timeout", 0, 1);
  endtask

  // Reset with output check, then release and expect a clean placement.
  task automatic do_reset();
    int consumed, n;
    @(negedge clk);
    reset = 1'b1;
    move_tick = 1'b0;
    feed_x.delete(); feed_y.delete();
    exp_ax.delete(); exp_ay.delete(); exp_trig.delete(); exp_score.delete();
    score_m = 0;
    @(posedge clk);
    #1;
    chk("rst_apple_x", int'(apple_x), 0);
    chk("rst_apple_y", int'(apple_y), 0);
    chk("rst_apple_valid", int'(apple_valid), 0);
    chk("rst_eaten", int'(eaten), 0);
    chk("rst_score", int'(score), 0);
    chk("rst_trigger", int'(new_number_trigger), 0);
    chk("rst_seg_addr", int'(seg_addr), 0);
    @(negedge clk);
    expect_place(1'b1, consumed);
    reset = 1'b0;
    wait_placed(400, n);
    if (consumed == 1) chk("first_place_latency_ok", int'(n <= 5 + int'(snake_len)), 1);
  endtask

  task automatic start_eat();
    int consumed;
    expect_place(1'b0, consumed);
    score_m = (score_m < SCORE_MAX) ? score_m + 1 : SCORE_MAX;
    exp_score.push_back(score_m);
    @(negedge clk);
    head_x = BIT'(exp_ax.size() > 1 ? exp_ax[exp_ax.size() - 2] : 0);
    head_y = BIT'(exp_ay.size() > 1 ? exp_ay[exp_ay.size() - 2] : 0);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    @(negedge clk);
    move_tick = 1'b1;  // arrives outside IDLE, must not count again
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  // Eat the apple currently at (cur_ax, cur_ay) and wait for the re-placement.
  task automatic eat_and_place();
    int n;
    int old_x = cur_ax, old_y = cur_ay;
    // A head that misses the apple must not eat.
    @(negedge clk);
    head_x = BIT'(old_x ^ GRID);
    head_y = BIT'(old_y);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    exp_ax.push_front(old_x);  // dummy entry, popped by start_eat_with_head
    exp_ay.push_front(old_y);
    start_eat_with_head(old_x, old_y);
    wait_placed(600, n);
  endtask

  task automatic start_eat_with_head(input int hx, input int hy);
    int consumed;
    void'(exp_ax.pop_front());
    void'(exp_ay.pop_front());
    expect_place(1'b0, consumed);
    score_m = (score_m < SCORE_MAX) ? score_m + 1 : SCORE_MAX;
    exp_score.push_back(score_m);
    @(negedge clk);
    head_x = BIT'(hx);
    head_y = BIT'(hy);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
    @(negedge clk);
    move_tick = 1'b1;
    @(negedge clk);
    move_tick = 1'b0;
  endtask

  initial begin
    int n;
    // Initial placement: single segment at (0,0), reset candidate (200,240).
    set_body(1);
    body_x[0] = '0; body_y[0] = '0;
    cand_x.delete(); cand_y.delete();
    cand_x.push_back(200); cand_y.push_back(240);
    do_reset();

    // Directed: (100,60) lands on body (96,48), (330,200) accepted as (320,192).
    body_x[0] = BIT'(192); body_y[0] = BIT'(240);
    body_x[1] = BIT'(96);  body_y[1] = BIT'(48);
    snake_len = LEN_W'(2);
    cand_x.delete(); cand_y.delete();
    cand_x.push_back(100); cand_y.push_back(60);
    cand_x.push_back(330); cand_y.push_back(200);
    eat_and_place();

    // Body covers every candidate: MAX_RETRY+1 triggers, last one accepted.
    set_body(12);
    cand_x.delete(); cand_y.delete();
    for (int i = 0; i <= MAX_RETRY; i++) begin
      cand_x.push_back(int'(body_x[i]) + int'($urandom_range(GRID - 1)));
      cand_y.push_back(int'(body_y[i]) + int'($urandom_range(GRID - 1)));
    end
    eat_and_place();

    // Randomized rounds with mixed collision rates and lengths.
    for (int r = 0; r < 30; r++) begin
      set_body(1 + int'($urandom_range(40)));
      fill_random(int'($urandom_range(80)), 1'b0);
      eat_and_place();
    end

    // Drive the score to saturation and beyond.
    set_body(1);
    while (score_m < SCORE_MAX + 0) begin
      fill_random(0, 1'b0);
      eat_and_place();
    end
    for (int r = 0; r < 2; r++) begin
      fill_random(20, 1'b0);
      eat_and_place();
    end

    // Reset in the middle of a long segment scan.
    set_body(40);
    fill_random(0, 1'b0);
    start_eat_with_head_wrap();
    n = 0;
    while (int'(seg_addr) < 3 && n < 60) begin
      @(negedge clk);
      n++;
    end
    chk("reached_check_ok", int'(int'(seg_addr) >= 3), 1);
    fill_random(30, 1'b1);
    do_reset();

    // Normal operation resumes with the score counting from zero.
    for (int r = 0; r < 3; r++) begin
      set_body(1 + int'($urandom_range(20)));
      fill_random(50, 1'b0);
      eat_and_place();
    end

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_ax.size() + exp_score.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  task automatic start_eat_with_head_wrap();
    exp_ax.push_front(cur_ax);
    exp_ay.push_front(cur_ay);
    start_eat_with_head(cur_ax, cur_ay);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

endmodule
